sysid_uptime_regs: RTL and testbench

- Parametrised system-identification slave, the successor to the fixed two-word ID/timestamp block.
- Sits on the Avalon-MM data master as a control slave.
- Provides ID, build timestamp and version words, a scratch register, and a prescaled 64-bit uptime counter with atomic hi/lo snapshot and a wrap interrupt.
- Software uses it to confirm hardware/software build match and to get a free-running time base.

---
 rtl/sysid_uptime_regs.sv | 159 +++++++++++++++
 tb/tb_sysid_uptime_regs.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_uptime_regs.sv
// System-ID / build-info slave with a prescaled 64-bit uptime counter, atomic hi/lo snapshot and wrap irq.
// Latency: reads return exactly one clock after the read strobe is sampled; writes take effect at that edge.
// Backpressure: none -- no waitrequest, one transfer per clock accepted unconditionally.
//
// Ports:
//   clock, reset_n            : rising-edge clock, asynchronous active-low reset
//   address/read/write        : Avalon-MM word address and single-cycle strobes (read wins on a collision)
//   writedata/byteenable      : write data and byte lanes
//   readdata/readdatavalid    : registered read data and its one-cycle valid pulse
//   irq                       : registered level interrupt, WRAP & IRQ_EN
module sysid_uptime_regs #(
   parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
   parameter logic [15:0] VERSION       = 16'h0001,
   parameter int unsigned PRESCALE      = 1,
   parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
   parameter int unsigned ADDR_W        = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic [31:0]       readdata,
   output logic              readdatavalid,
   output logic              irq
);

   localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_TSTAMP  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_UP_LO   = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_UP_HI   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_INFO    = ADDR_W'(6);

   localparam logic [15:0] PS_MAX    = 16'(PRESCALE - 1);
   localparam logic [15:0] PS_FIELD  = 16'(PRESCALE);

   logic [63:0] cnt;
   logic [15:0] presc;
   logic [31:0] hi_snap;
   logic [31:0] scratch;
   logic        en;
   logic        wrap;
   logic        irq_en;

   logic        wr_ok;
   logic        wr_lo;
   logic        wr_hi;
   logic        cnt_wr;
   logic        ctrl_wr;
   logic        clr;
   logic        tick;
   logic        wrap_evt;
   logic [31:0] rd_mux;

   function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

   // A write sampled together with a read is dropped.
   assign wr_ok    = write & ~read;
   assign wr_lo    = wr_ok && (address == A_UP_LO);
   assign wr_hi    = wr_ok && (address == A_UP_HI);
   assign cnt_wr   = wr_lo | wr_hi;
   assign ctrl_wr  = wr_ok && (address == A_CTRL) && byteenable[0];
   assign clr      = ctrl_wr & writedata[1];
   assign tick     = en && (presc == PS_MAX);
   // A wrap only counts when the increment really happens (CLR and counter writes win).
   assign wrap_evt = tick && !clr && !cnt_wr && (cnt == '1);

   always_comb begin
      rd_mux = 32'h0;
      case (address)
         A_ID:      rd_mux = SYSTEM_ID;
         A_TSTAMP:  rd_mux = TIMESTAMP;
         A_SCRATCH: rd_mux = scratch;
         A_UP_LO:   rd_mux = cnt[31:0];
         A_UP_HI:   rd_mux = hi_snap;
         A_CTRL:    rd_mux = {28'h0, irq_en, wrap, 1'b0, en};
         A_INFO:    rd_mux = {PS_FIELD, VERSION};
         default:   rd_mux = 32'h0;
      endcase
   end

   // Uptime counter and prescaler: CLR > counter write > tick.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt   <= 64'h0;
         presc <= 16'h0;
      end else if (clr) begin
         cnt   <= 64'h0;
         presc <= 16'h0;
      end else if (cnt_wr) begin
         if (wr_lo) cnt[31:0]  <= be_merge(cnt[31:0], writedata, byteenable);
         if (wr_hi) cnt[63:32] <= be_merge(cnt[63:32], writedata, byteenable);
         presc <= 16'h0;
      end else if (en) begin
         if (tick) begin
            presc <= 16'h0;
            cnt   <= cnt + 64'd1;
         end else begin
            presc <= presc + 16'd1;
         end
      end
   end

   // Control/status bits; a wrap at the same edge as a W1C keeps WRAP set.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         en     <= 1'b1;
         irq_en <= 1'b0;
         wrap   <= 1'b0;
         irq    <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            en     <= writedata[0];
            irq_en <= writedata[3];
         end
         if (wrap_evt)                   wrap <= 1'b1;
         else if (ctrl_wr && writedata[2]) wrap <= 1'b0;
         irq <= wrap & irq_en;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch <= SCRATCH_RESET;
      end else if (wr_ok && (address == A_SCRATCH)) begin
         scratch <= be_merge(scratch, writedata, byteenable);
      end
   end

   // Read port; the LO read freezes the upper half so a later HI read pairs with it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         readdata      <= 32'h0;
         readdatavalid <= 1'b0;
         hi_snap       <= 32'h0;
      end else begin
         readdatavalid <= read;
         if (read) begin
            readdata <= rd_mux;
            if (address == A_UP_LO) hi_snap <= cnt[63:32];
         end
      end
   end

endmodule

// File: tb/tb_sysid_uptime_regs.sv
`timescale 1ns/1ps
module tb_sysid_uptime_regs;

   localparam logic [31:0] SYS_ID = 32'h1234_ABCD;
   localparam logic [31:0] TSTAMP = 32'd1537775151;
   localparam logic [15:0] VER    = 16'h0002;
   localparam int          PS     = 4;
   localparam int          AW     = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] address = '0;
   logic          read = 1'b0;
   logic          write = 1'b0;
   logic [31:0]   writedata = '0;
   logic [3:0]    byteenable = '0;
   logic [31:0]   readdata;
   logic          readdatavalid;
   logic          irq;

   sysid_uptime_regs #(
      .SYSTEM_ID(SYS_ID), .TIMESTAMP(TSTAMP), .VERSION(VER),
      .PRESCALE(PS), .SCRATCH_RESET(32'h0), .ADDR_W(AW)
   ) dut (
      .clock(clock), .reset_n(reset_n), .address(address), .read(read),
      .write(write), .writedata(writedata), .byteenable(byteenable),
      .readdata(readdata), .readdatavalid(readdatavalid), .irq(irq)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc++;

   int n_cmp = 0;
   int n_bad = 0;

   // Scoreboard: expected data and the edge at which the read was sampled.
   string       sb_tag[$];
   logic [31:0] sb_dat[$];
   int          sb_edge[$];

   // Uptime model: value after edge e is m_val + (e - m_base)/PS while enabled.
   logic [63:0] m_val;
   int          m_base;
   bit          m_en;
   logic [31:0] m_snap;

   function automatic logic [63:0] cnt_at(input int e);
      if (!m_en || e <= m_base) return m_val;
      return m_val + 64'((e - m_base) / PS);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n && readdatavalid) begin
         n_cmp++;
         assert (sb_dat.size() != 0) else begin
            n_bad++;
            $error("FAIL rdv_unexpected: observed readdatavalid=1 data %h expected no pending read", readdata);
         end
         if (sb_dat.size() != 0) begin
            check({sb_tag[0], "_latency"}, 32'(cyc), 32'(sb_edge[0]));
            check(sb_tag[0], readdata, sb_dat[0]);
            void'(sb_tag.pop_front());
            void'(sb_dat.pop_front());
            void'(sb_edge.pop_front());
         end
      end
   end

   task automatic push_exp(input string tag, input logic [31:0] d);
      sb_tag.push_back(tag);
      sb_dat.push_back(d);
      sb_edge.push_back(cyc + 1);
   endtask

   task automatic bus_idle();
      @(negedge clock);
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clock);
      address = AW'(a); read = 1'b0; write = 1'b1; writedata = d; byteenable = be;
   endtask

   task automatic bus_read(input string tag, input int a, input logic [31:0] exp);
      @(negedge clock);
      address = AW'(a); read = 1'b1; write = 1'b0;
      push_exp(tag, exp);
   endtask

   task automatic bus_read_lo(input string tag);
      logic [63:0] v;
      @(negedge clock);
      address = AW'(3); read = 1'b1; write = 1'b0;
      v = cnt_at(cyc);
      m_snap = v[63:32];
      push_exp(tag, v[31:0]);
   endtask

   task automatic bus_read_hi(input string tag);
      @(negedge clock);
      address = AW'(4); read = 1'b1; write = 1'b0;
      push_exp(tag, m_snap);
   endtask

   // Counter loads are only issued while the model is frozen (EN=0).
   task automatic bus_write_cnt(input int a, input logic [31:0] d);
      bus_write(a, d, 4'hF);
      if (a == 3) m_val[31:0] = d;
      else        m_val[63:32] = d;
   endtask

   task automatic ctrl_write(input logic [31:0] d);
      int e;
      bus_write(5, d, 4'h1);
      e = cyc + 1;
      if (d[1]) begin
         m_val = 64'h0; m_base = e; m_en = d[0];
      end else if (m_en && !d[0]) begin
         m_val = cnt_at(e); m_en = 1'b0;
      end else if (!m_en && d[0]) begin
         m_base = e; m_en = 1'b1;
      end
   endtask

   task automatic release_reset();
      @(negedge clock);
      reset_n = 1'b1;
      m_val = 64'h0; m_base = cyc; m_en = 1'b1; m_snap = 32'h0;
   endtask

   initial begin
      int we;
      int wc;
      repeat (3) @(negedge clock);
      check("rst_readdata", readdata, 32'h0);
      check("rst_rdv", {31'h0, readdatavalid}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      release_reset();

      // Identification words back-to-back, plus an out-of-range word.
      bus_read("id", 0, SYS_ID);
      bus_read("tstamp", 1, TSTAMP);
      bus_read("word9", 9, 32'h0);
      bus_read("info", 6, {16'(PS), VER});
      bus_idle();
      @(negedge clock);
      check("rdv_drop", {31'h0, readdatavalid}, 32'h0);
      check("rd_hold", readdata, {16'(PS), VER});

      // Scratch byte lanes, unmapped word, read/write collision.
      bus_read("scratch_rst", 2, 32'h0);
      bus_write(2, 32'hDEAD_BEEF, 4'hF);
      bus_write(2, 32'h0000_0055, 4'h1);
      bus_read("scratch_be", 2, 32'hDEAD_BE55);
      bus_write(7, 32'hFFFF_FFFF, 4'hF);
      bus_read("word7", 7, 32'h0);
      @(negedge clock);
      address = AW'(2); read = 1'b1; write = 1'b1; writedata = 32'h0; byteenable = 4'hF;
      push_exp("rw_read", 32'hDEAD_BE55);
      bus_read("rw_dropped", 2, 32'hDEAD_BE55);
      bus_idle();

      // Free-running count ~40 clocks after reset, then freeze.
      while (cyc < m_base + 40) bus_idle();
      bus_read_lo("up40_lo");
      bus_read_hi("up40_hi");
      ctrl_write(32'h0);
      repeat (20) bus_idle();
      bus_read_lo("frozen_lo");

      // LO->HI carry, read after the tick.
      bus_write_cnt(4, 32'h0000_0001);
      bus_write_cnt(3, 32'hFFFF_FFFF);
      ctrl_write(32'h1);
      repeat (4) bus_idle();
      bus_read_lo("carry_lo");
      bus_read_hi("carry_hi");

      // LO read on the carry edge: HI must return the snapshot, not the new value.
      ctrl_write(32'h0);
      bus_write_cnt(4, 32'h0000_0001);
      bus_write_cnt(3, 32'hFFFF_FFFF);
      ctrl_write(32'h1);
      repeat (3) bus_idle();
      bus_read_lo("snap_lo");
      bus_read_hi("snap_hi");
      bus_read_lo("snap_lo2");
      bus_read_hi("snap_hi2");

      // 64-bit wrap sets WRAP; irq follows a cycle later.
      ctrl_write(32'h0);
      bus_write_cnt(4, 32'hFFFF_FFFF);
      bus_write_cnt(3, 32'hFFFF_FFFF);
      ctrl_write(32'h9);
      we = cyc + 1;
      while (cyc < we + PS) bus_idle();
      check("wrap_irq_lag", {31'h0, irq}, 32'h0);
      bus_idle();
      check("wrap_irq", {31'h0, irq}, 32'h1);
      bus_read("ctrl_wrap", 5, 32'hD);
      bus_read_lo("wrap_lo");

      // CLR on a tick edge: counter cleared, WRAP untouched.
      bus_idle();
      while (((cyc + 1 - m_base) % PS) != 0) bus_idle();
      ctrl_write(32'hB);
      bus_read_lo("clr_lo");
      bus_read("ctrl_clr", 5, 32'hD);
      bus_idle();
      check("clr_irq_kept", {31'h0, irq}, 32'h1);

      // WRAP W1C drops irq one cycle later.
      ctrl_write(32'hD);
      bus_idle();
      check("w1c_irq_lag", {31'h0, irq}, 32'h1);
      bus_idle();
      check("w1c_irq", {31'h0, irq}, 32'h0);
      bus_read("ctrl_w1c", 5, 32'h9);

      // Reset asserted between edges while a read is in flight.
      repeat (10) bus_idle();
      @(negedge clock);
      address = AW'(3); read = 1'b1; write = 1'b0;
      @(posedge clock);
      #1;
      check("inflight_rdv", {31'h0, readdatavalid}, 32'h1);
      reset_n = 1'b0;
      #1;
      check("async_rst_rdv", {31'h0, readdatavalid}, 32'h0);
      check("async_rst_data", readdata, 32'h0);
      check("async_rst_irq", {31'h0, irq}, 32'h0);
      repeat (2) @(negedge clock);
      read = 1'b0;
      release_reset();
      @(negedge clock);
      check("no_rdv_from_reset", {31'h0, readdatavalid}, 32'h0);
      bus_read("ctrl_after_rst", 5, 32'h1);
      bus_read_hi("snap_after_rst");
      bus_read_lo("lo_after_rst");
      bus_read("scratch_after_rst", 2, 32'h0);
      repeat (3) bus_idle();
      check("sb_drain", 32'(sb_dat.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      n_bad++;
      $display("FAIL watchdog: observed no completion by %0t expected completion", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
